lsu_mem_controller: RTL and testbench

//   Responder side of the LSU memory handshake. Arbitrates NUM_CONSUMERS LSU read/write requests

---
 rtl/lsu_mem_controller.sv | 175 +++++++++++++++++
 tb/tb_lsu_mem_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_controller.sv
// Responder side of the LSU memory handshake: round-robin arbitration of per-consumer
// read/write requests onto one external memory port, with registered relay of data and acks.
module lsu_mem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
  output logic                               mem_read_valid,
  output logic [ADDR_BITS-1:0]               mem_read_address,
  input  logic                               mem_read_ready,
  input  logic [DATA_BITS-1:0]               mem_read_data,
  output logic                               mem_write_valid,
  output logic [ADDR_BITS-1:0]               mem_write_address,
  output logic [DATA_BITS-1:0]               mem_write_data,
  input  logic                               mem_write_ready
);

  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELAY
  } state_e;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0]                 grant_q, grant_d;
  logic                             memReadValid_q, memReadValid_d;
  logic [ADDR_BITS-1:0]             memReadAddr_q, memReadAddr_d;
  logic                             memWriteValid_q, memWriteValid_d;
  logic [ADDR_BITS-1:0]             memWriteAddr_q, memWriteAddr_d;
  logic [DATA_BITS-1:0]             memWriteData_q, memWriteData_d;
  logic [NUM_CONSUMERS-1:0]         readReady_q, readReady_d;
  logic [NUM_CONSUMERS-1:0]         writeReady_q, writeReady_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] readData_q, readData_d;

  logic pickFound;
  logic pickRead;
  int   pickIdx;
  int   scanIdx;
  int   grantSel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      rrPtr_q         <= '0;
      grant_q         <= '0;
      memReadValid_q  <= 1'b0;
      memReadAddr_q   <= '0;
      memWriteValid_q <= 1'b0;
      memWriteAddr_q  <= '0;
      memWriteData_q  <= '0;
      readReady_q     <= '0;
      writeReady_q    <= '0;
      readData_q      <= '0;
    end else begin
      state_q         <= state_d;
      rrPtr_q         <= rrPtr_d;
      grant_q         <= grant_d;
      memReadValid_q  <= memReadValid_d;
      memReadAddr_q   <= memReadAddr_d;
      memWriteValid_q <= memWriteValid_d;
      memWriteAddr_q  <= memWriteAddr_d;
      memWriteData_q  <= memWriteData_d;
      readReady_q     <= readReady_d;
      writeReady_q    <= writeReady_d;
      readData_q      <= readData_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    rrPtr_d         = rrPtr_q;
    grant_d         = grant_q;
    memReadValid_d  = memReadValid_q;
    memReadAddr_d   = memReadAddr_q;
    memWriteValid_d = memWriteValid_q;
    memWriteAddr_d  = memWriteAddr_q;
    memWriteData_d  = memWriteData_q;
    readReady_d     = readReady_q;
    writeReady_d    = writeReady_q;
    readData_d      = readData_q;
    pickFound       = 1'b0;
    pickRead        = 1'b0;
    pickIdx         = 0;
    scanIdx         = 0;
    grantSel        = int'(grant_q);

    // Round-robin scan starting at rrPtr; a consumer with both requests is served read first.
    for (int i = 0; i < NUM_CONSUMERS; i++) begin
      scanIdx = int'(rrPtr_q) + i;
      if (scanIdx >= NUM_CONSUMERS) begin
        scanIdx = scanIdx - NUM_CONSUMERS;
      end
      if (!pickFound && (consumer_read_valid[scanIdx] || consumer_write_valid[scanIdx])) begin
        pickFound = 1'b1;
        pickIdx   = scanIdx;
        pickRead  = consumer_read_valid[scanIdx];
      end
    end

    case (state_q)
      IDLE: begin
        if (pickFound) begin
          grant_d = IDX_W'(pickIdx);
          if (pickRead) begin
            memReadValid_d = 1'b1;
            memReadAddr_d  = consumer_read_address[pickIdx*ADDR_BITS +: ADDR_BITS];
            state_d        = READ_WAIT;
          end else begin
            memWriteValid_d = 1'b1;
            memWriteAddr_d  = consumer_write_address[pickIdx*ADDR_BITS +: ADDR_BITS];
            memWriteData_d  = consumer_write_data[pickIdx*DATA_BITS +: DATA_BITS];
            state_d         = WRITE_WAIT;
          end
        end
      end

      READ_WAIT: begin
        if (mem_read_ready) begin
          memReadValid_d                                  = 1'b0;
          readData_d[grantSel*DATA_BITS +: DATA_BITS]     = mem_read_data;
          readReady_d                                     = '0;
          readReady_d[grantSel]                           = 1'b1;
          state_d                                         = RELAY;
        end
      end

      WRITE_WAIT: begin
        if (mem_write_ready) begin
          memWriteValid_d         = 1'b0;
          writeReady_d            = '0;
          writeReady_d[grantSel]  = 1'b1;
          state_d                 = RELAY;
        end
      end

      RELAY: begin
        // Ready is held until the granted consumer withdraws the request it was served for.
        if ((|readReady_q) ? !consumer_read_valid[grantSel] : !consumer_write_valid[grantSel]) begin
          readReady_d  = '0;
          writeReady_d = '0;
          rrPtr_d      = (grant_q == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : grant_q + 1'b1;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign consumer_read_ready  = readReady_q;
  assign consumer_read_data   = readData_q;
  assign consumer_write_ready = writeReady_q;
  assign mem_read_valid       = memReadValid_q;
  assign mem_read_address     = memReadAddr_q;
  assign mem_write_valid      = memWriteValid_q;
  assign mem_write_address    = memWriteAddr_q;
  assign mem_write_data       = memWriteData_q;

endmodule

// File: tb/tb_lsu_mem_controller.sv
// Randomized bench for lsu_mem_controller: drives consumer requests and a memory responder,
// predicting grant order, memory traffic and relayed data from a transaction-level model.
module tb_lsu_mem_controller;

  localparam int N  = 4;
  localparam int AB = 8;
  localparam int DB = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      consumer_read_valid;
  logic [N*AB-1:0]   consumer_read_address;
  logic [N-1:0]      consumer_read_ready;
  logic [N*DB-1:0]   consumer_read_data;
  logic [N-1:0]      consumer_write_valid;
  logic [N*AB-1:0]   consumer_write_address;
  logic [N*DB-1:0]   consumer_write_data;
  logic [N-1:0]      consumer_write_ready;
  logic              mem_read_valid;
  logic [AB-1:0]     mem_read_address;
  logic              mem_read_ready;
  logic [DB-1:0]     mem_read_data;
  logic              mem_write_valid;
  logic [AB-1:0]     mem_write_address;
  logic [DB-1:0]     mem_write_data;
  logic              mem_write_ready;

  lsu_mem_controller #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  int            rrModel;
  logic          pendR  [N];
  logic          pendW  [N];
  logic [AB-1:0] rdAddr [N];
  logic [AB-1:0] wrAddr [N];
  logic [DB-1:0] wrData [N];
  logic [DB-1:0] expRdata [N];
  logic [DB-1:0] memModel [256];
  int            grantLog[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive the consumer-side request lines from the bench's pending-request tables.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      consumer_read_valid[i]              = pendR[i];
      consumer_read_address[i*AB +: AB]   = rdAddr[i];
      consumer_write_valid[i]             = pendW[i];
      consumer_write_address[i*AB +: AB]  = wrAddr[i];
      consumer_write_data[i*DB +: DB]     = wrData[i];
    end
  endtask

  function automatic logic [N*DB-1:0] packRdata();
    logic [N*DB-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DB +: DB] = expRdata[i];
    return v;
  endfunction

  function automatic logic anyPending();
    logic p;
    p = 1'b0;
    for (int i = 0; i < N; i++) p = p | pendR[i] | pendW[i];
    return p;
  endfunction

  function automatic void clearPending();
    for (int i = 0; i < N; i++) begin
      pendR[i] = 1'b0;
      pendW[i] = 1'b0;
    end
  endfunction

  // One arbitrated transaction: predict winner, serve memory after hold cycles, release.
  task automatic runOne(input int holdArg);
    int            g;
    logic          isRead;
    int            waitCnt;
    int            hold;
    int            extra;
    logic [AB-1:0] a;
    logic [N-1:0]  oneHot;
    g = -1;
    isRead = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (rrModel + k) % N;
      if (g < 0 && (pendR[c] || pendW[c])) begin
        g = c;
        isRead = pendR[c];
      end
    end
    waitCnt = 0;
    while (!(mem_read_valid || mem_write_valid) && waitCnt < 8) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 8) begin
      checkOutput("memReqTimeout", 64'(waitCnt), 64'd1);
      clearPending();
      applyStimulus();
      return;
    end
    checkOutput("reqToMemLatency", 64'(waitCnt), 64'd1);
    checkOutput("memReqType", 64'({mem_read_valid, mem_write_valid}), isRead ? 64'd2 : 64'd1);
    a = isRead ? rdAddr[g] : wrAddr[g];
    checkOutput("memAddr", 64'(isRead ? mem_read_address : mem_write_address), 64'(a));
    if (!isRead) checkOutput("memWData", 64'(mem_write_data), 64'(wrData[g]));
    hold = (holdArg < 0) ? int'($urandom_range(0, 3)) : holdArg;
    for (int h = 0; h < hold; h++) begin
      mem_read_ready  = isRead ? 1'b0 : 1'($urandom_range(0, 1));
      mem_write_ready = isRead ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      checkOutput("holdValid", 64'({mem_read_valid, mem_write_valid}), isRead ? 64'd2 : 64'd1);
      checkOutput("holdAddr", 64'(isRead ? mem_read_address : mem_write_address), 64'(a));
      checkOutput("holdNoReady", 64'({consumer_read_ready, consumer_write_ready}), 64'd0);
    end
    if (isRead) begin
      mem_read_ready  = 1'b1;
      mem_write_ready = 1'b0;
      mem_read_data   = memModel[a];
      expRdata[g]     = memModel[a];
    end else begin
      mem_write_ready = 1'b1;
      mem_read_ready  = 1'b0;
      memModel[a]     = wrData[g];
    end
    @(negedge clk);
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = 8'($urandom);
    oneHot = '0;
    oneHot[g] = 1'b1;
    grantLog.push_back(g);
    checkOutput("memValidDropped", 64'({mem_read_valid, mem_write_valid}), 64'd0);
    checkOutput("consumerReady", 64'({consumer_read_ready, consumer_write_ready}),
                isRead ? 64'({oneHot, 4'b0}) : 64'({4'b0, oneHot}));
    checkOutput("readDataSlots", 64'(consumer_read_data), 64'(packRdata()));
    extra = int'($urandom_range(0, 2));
    for (int e = 0; e < extra; e++) begin
      @(negedge clk);
      checkOutput("readyHeld", 64'({consumer_read_ready, consumer_write_ready}),
                  isRead ? 64'({oneHot, 4'b0}) : 64'({4'b0, oneHot}));
    end
    if (isRead) pendR[g] = 1'b0;
    else        pendW[g] = 1'b0;
    applyStimulus();
    @(negedge clk);
    checkOutput("readyReleased", 64'({consumer_read_ready, consumer_write_ready}), 64'd0);
    checkOutput("readDataKept", 64'(consumer_read_data), 64'(packRdata()));
    rrModel = (g + 1) % N;
  endtask

  task automatic runRound(input int hold);
    applyStimulus();
    while (anyPending()) runOne(hold);
  endtask

  task automatic checkOrder(input string tag, input int exp[4]);
    checkOutput({tag, "Count"}, 64'(grantLog.size()), 64'd4);
    for (int k = 0; k < 4 && k < grantLog.size(); k++) begin
      checkOutput(tag, 64'(grantLog[k]), 64'(exp[k]));
    end
  endtask

  initial begin
    int orderA[4];
    int orderB[4];
    reset_n = 1'b0;
    mem_read_ready = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data = '0;
    rrModel = 0;
    for (int i = 0; i < 256; i++) memModel[i] = 8'($urandom);
    for (int i = 0; i < N; i++) begin
      pendR[i] = 1'b0;
      pendW[i] = 1'b0;
      rdAddr[i] = '0;
      wrAddr[i] = '0;
      wrData[i] = '0;
      expRdata[i] = '0;
    end
    applyStimulus();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("resetValids", 64'({mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready}), 64'd0);
    checkOutput("resetAddrData", 64'({mem_read_address, mem_write_address, mem_write_data}), 64'd0);
    checkOutput("resetRdata", 64'(consumer_read_data), 64'd0);

    // All four consumers read at once from rr=0.
    grantLog.delete();
    for (int i = 0; i < N; i++) begin
      pendR[i] = 1'b1;
      rdAddr[i] = 8'($urandom);
    end
    runRound(-1);
    orderA = '{0, 1, 2, 3};
    checkOrder("rrOrderFrom0", orderA);

    // A lone consumer-1 read moves the pointer to 2.
    pendR[1] = 1'b1;
    rdAddr[1] = 8'h21;
    runRound(0);
    grantLog.delete();
    for (int i = 0; i < N; i++) begin
      pendR[i] = 1'b1;
      rdAddr[i] = 8'($urandom);
    end
    runRound(-1);
    orderB = '{2, 3, 0, 1};
    checkOrder("rrOrderFrom2", orderB);

    pendR[2] = 1'b1;
    rdAddr[2] = 8'h3C;
    memModel[8'h3C] = 8'hA5;
    runRound(2);
    checkOutput("singleReadSlot2", 64'(consumer_read_data[2*DB +: DB]), 64'hA5);

    pendW[0] = 1'b1;
    wrAddr[0] = 8'h10;
    wrData[0] = 8'h7E;
    runRound(1);

    grantLog.delete();
    pendR[3] = 1'b1;
    pendW[3] = 1'b1;
    rdAddr[3] = 8'h44;
    wrAddr[3] = 8'h45;
    wrData[3] = 8'h99;
    runRound(0);
    checkOutput("readWriteSameCount", 64'(grantLog.size()), 64'd2);

    pendR[1] = 1'b1;
    rdAddr[1] = 8'h77;
    runRound(10);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) begin
        pendR[i]  = 1'($urandom_range(0, 1));
        pendW[i]  = ($urandom_range(0, 2) == 0);
        rdAddr[i] = 8'($urandom);
        wrAddr[i] = 8'($urandom);
        wrData[i] = 8'($urandom);
      end
      if (!anyPending()) pendW[$urandom_range(0, N-1)] = 1'b1;
      runRound(-1);
    end

    // Reset in the middle of a read wait abandons the transaction.
    pendR[1] = 1'b1;
    rdAddr[1] = 8'h55;
    applyStimulus();
    repeat (2) @(negedge clk);
    checkOutput("preResetReadValid", 64'(mem_read_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("midResetValids", 64'({mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready}), 64'd0);
    checkOutput("midResetAddrData", 64'({mem_read_address, mem_write_address, mem_write_data}), 64'd0);
    checkOutput("midResetRdata", 64'(consumer_read_data), 64'd0);
    clearPending();
    applyStimulus();
    for (int i = 0; i < N; i++) expRdata[i] = '0;
    rrModel = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("postResetIdle", 64'({mem_read_valid, mem_write_valid, consumer_read_ready, consumer_write_ready}), 64'd0);

    grantLog.delete();
    pendR[2] = 1'b1;
    pendW[3] = 1'b1;
    rdAddr[2] = 8'h12;
    wrAddr[3] = 8'h34;
    wrData[3] = 8'h56;
    runRound(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
